// File: rtl/router_pkg.sv
// Shared constants, header layout and FSM state type for the router ingress framer.
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 63;
    localparam int LEN_W   = 6;
    localparam int ADDR_W  = 2;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam logic [ADDR_W-1:0] PORT0        = 2'd0;
    localparam logic [ADDR_W-1:0] PORT1        = 2'd1;
    localparam logic [ADDR_W-1:0] PORT2        = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] addr);
        logic [7:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host-side and router-side signals of the packet framer, bundled with DUT/driver views.
interface router_pkt_tx_if #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int CNT_W  = 7
) ();

    logic                          wr_en;
    logic [DATA_W-1:0]             wr_data;
    logic                          buf_full;
    logic [CNT_W-1:0]              buf_count;
    logic                          wr_ovf;
    logic                          start;
    logic [router_pkg::LEN_W-1:0]  cmd_len;
    logic [router_pkg::ADDR_W-1:0] cmd_addr;
    logic                          cmd_ready;
    logic                          cmd_err;
    logic                          busy;
    logic                          pkt_valid;
    logic [DATA_W-1:0]             pkt_data;
    logic                          tx_active;
    logic                          tx_done;

    modport slave (
        input  wr_en, wr_data, start, cmd_len, cmd_addr, busy,
        output buf_full, buf_count, wr_ovf, cmd_ready, cmd_err,
               pkt_valid, pkt_data, tx_active, tx_done
    );

    modport master (
        output wr_en, wr_data, start, cmd_len, cmd_addr, busy,
        input  buf_full, buf_count, wr_ovf, cmd_ready, cmd_err,
               pkt_valid, pkt_data, tx_active, tx_done
    );

endinterface

// File: rtl/router_tx_fifo.sv
// Payload byte buffer: synchronous FIFO with show-ahead head and head+1 outputs.
module router_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [DATA_W-1:0] head_next_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign rd_next     = wrap_inc(rd_ptr_q);
    assign head_o      = mem_q[rd_ptr_q];
    assign head_next_o = mem_q[rd_next];
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_i && full_o;
        if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = rd_next;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Ingress framer feeding the 1x3 router: header, buffered payload, then XOR parity, stalling on busy.
module router_pkt_tx #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 7
) (
    input logic            clk,
    input logic            rst,
    router_pkt_tx_if.slave bus
);

    import router_pkg::*;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              tx_done_q, tx_done_d;
    logic              cmd_err_q, cmd_err_d;

    logic              accept;
    logic              cmd_legal;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head, fifo_head_next;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_ovf;
    logic [DATA_W-1:0] hdr_byte;

    router_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_en),
        .data_i      (bus.wr_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .head_next_o (fifo_head_next),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ovf_o       (fifo_ovf)
    );

    // The length check against occupancy is what keeps the payload phase from underflowing.
    assign cmd_legal = (bus.cmd_addr inside {PORT0, PORT1, PORT2})
                    && (bus.cmd_len != '0)
                    && (fifo_count >= CNT_W'(bus.cmd_len));
    assign accept    = (state_q != IDLE) && !bus.busy;
    assign hdr_byte  = DATA_W'(make_header(bus.cmd_len, bus.cmd_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && cmd_legal)         state_d = HEADER;
            HEADER:  if (accept)                         state_d = PAYLOAD;
            PAYLOAD: if (accept && rem_q == LEN_W'(1))   state_d = PARITY;
            PARITY:  if (accept)                         state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_data_d = pkt_data_q;
        parity_d   = parity_q;
        rem_d      = rem_q;
        tx_done_d  = 1'b0;
        cmd_err_d  = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (cmd_legal) begin
                        pkt_data_d = hdr_byte;
                        parity_d   = hdr_byte;
                        rem_d      = bus.cmd_len;
                    end else begin
                        cmd_err_d  = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (accept) pkt_data_d = fifo_head;
            end
            PAYLOAD: begin
                // The popped byte is the one on the wire, so the next one comes from head+1.
                if (accept) begin
                    fifo_pop   = !fifo_empty;
                    parity_d   = parity_q ^ pkt_data_q;
                    rem_d      = rem_q - LEN_W'(1);
                    pkt_data_d = (rem_q == LEN_W'(1)) ? (parity_q ^ pkt_data_q) : fifo_head_next;
                end
            end
            PARITY: begin
                if (accept) begin
                    pkt_data_d = '0;
                    parity_d   = '0;
                    tx_done_d  = 1'b1;
                end
            end
            default: pkt_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_data_q <= '0;
            parity_q   <= '0;
            rem_q      <= '0;
            tx_done_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            pkt_data_q <= pkt_data_d;
            parity_q   <= parity_d;
            rem_q      <= rem_d;
            tx_done_q  <= tx_done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign bus.pkt_valid = (state_q == HEADER) || (state_q == PAYLOAD);
    assign bus.pkt_data  = pkt_data_q;
    assign bus.tx_active = (state_q != IDLE);
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.tx_done   = tx_done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.buf_full  = fifo_full;
    assign bus.buf_count = fifo_count;
    assign bus.wr_ovf    = fifo_ovf;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: queue-based buffer model plus per-packet expected byte stream.
module tb_router_pkt_tx;

    import router_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    router_pkt_tx_if #(.DATA_W(8), .CNT_W(7)) bus ();

    router_pkt_tx #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .CNT_W  (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic startV;
        int   len;
        int   addr;
        logic expErr;
    } errVec_t;

    int         tests    = 0;
    int         failures = 0;
    logic [7:0] modelQ[$];
    int         hold[0:64];
    bit         randWr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of host/router stimulus; the model buffer follows the same edge.
    task automatic applyStimulus(input logic wrEn, input logic [7:0] wrData,
                                 input logic busyV, input logic popExp);
        bit wasFull;
        bus.wr_en   = wrEn;
        bus.wr_data = wrData;
        bus.busy    = busyV;
        @(posedge clk);
        wasFull = (modelQ.size() == DEPTH);
        if (popExp) void'(modelQ.pop_front());
        if (wrEn && !wasFull) modelQ.push_back(wrData);
        #1;
        bus.wr_en = 1'b0;
        checkOutput("buf_count", 32'(bus.buf_count), modelQ.size());
        checkOutput("buf_full", 32'(bus.buf_full), 32'(modelQ.size() == DEPTH));
        checkOutput("wr_ovf", 32'(bus.wr_ovf), 32'(wrEn && wasFull));
    endtask

    task automatic pushByte(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
    endtask

    function automatic logic nextWr();
        return randWr && ($urandom_range(0, 2) == 0);
    endfunction

    // Expected stream: header = len*4+addr, the first len buffered bytes, XOR of all of them.
    task automatic runPacket(input int len, input int addr, input bit startInHeader);
        logic [7:0] exp[$];
        logic [7:0] par;
        exp.push_back(8'(len * 4 + addr));
        par = exp[0];
        for (int i = 0; i < len; i++) begin
            exp.push_back(modelQ[i]);
            par = par ^ modelQ[i];
        end
        exp.push_back(par);

        bus.start    = 1'b1;
        bus.cmd_len  = 6'(len);
        bus.cmd_addr = 2'(addr);
        applyStimulus(nextWr(), 8'($urandom), 1'b0, 1'b0);
        bus.start = 1'b0;

        for (int k = 0; k <= len + 1; k++) begin
            for (int h = 0; h <= hold[k]; h++) begin
                checkOutput("pkt_valid", 32'(bus.pkt_valid), 32'(k <= len));
                checkOutput("pkt_data", 32'(bus.pkt_data), 32'(exp[k]));
                checkOutput("tx_active", 32'(bus.tx_active), 32'd1);
                checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'd0);
                checkOutput("tx_done", 32'(bus.tx_done), 32'd0);
                checkOutput("cmd_err", 32'(bus.cmd_err), 32'd0);
                if (startInHeader && k == 0) begin
                    bus.start    = 1'b1;
                    bus.cmd_addr = ADDR_INVALID;
                end
                applyStimulus(nextWr(), 8'($urandom), 1'(h < hold[k]),
                              1'((h == hold[k]) && k >= 1 && k <= len));
                bus.start = 1'b0;
            end
        end

        checkOutput("tx_done_pulse", 32'(bus.tx_done), 32'd1);
        checkOutput("pkt_valid_end", 32'(bus.pkt_valid), 32'd0);
        checkOutput("pkt_data_end", 32'(bus.pkt_data), 32'd0);
        checkOutput("tx_active_end", 32'(bus.tx_active), 32'd0);
        checkOutput("cmd_ready_end", 32'(bus.cmd_ready), 32'd1);
        applyStimulus(nextWr(), 8'($urandom), 1'b0, 1'b0);
        checkOutput("tx_done_once", 32'(bus.tx_done), 32'd0);
        for (int k = 0; k <= 64; k++) hold[k] = 0;
    endtask

    errVec_t errTable[7];

    initial begin
        int len;
        int addr;
        int room;

        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.cmd_len  = '0;
        bus.cmd_addr = '0;
        bus.busy     = 1'b0;
        randWr       = 1'b0;
        for (int k = 0; k <= 64; k++) hold[k] = 0;

        #12;
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("rst_pkt_data", 32'(bus.pkt_data), 32'd0);
        checkOutput("rst_buf_count", 32'(bus.buf_count), 32'd0);
        checkOutput("rst_buf_full", 32'(bus.buf_full), 32'd0);
        checkOutput("rst_tx_active", 32'(bus.tx_active), 32'd0);
        checkOutput("rst_tx_done", 32'(bus.tx_done), 32'd0);
        checkOutput("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        checkOutput("rst_wr_ovf", 32'(bus.wr_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic five-byte packet to port 2.
        for (int i = 1; i <= 5; i++) pushByte(8'(i));
        runPacket(5, 2, 1'b0);

        // Same packet with three-cycle stalls on header, payload byte 3 and parity.
        for (int i = 1; i <= 5; i++) pushByte(8'(i));
        hold[0] = 3;
        hold[3] = 3;
        hold[6] = 3;
        runPacket(5, 2, 1'b1);

        for (int i = 0; i < 14; i++) pushByte(8'($urandom));
        runPacket(14, 0, 1'b0);
        for (int i = 0; i < 16; i++) pushByte(8'($urandom));
        runPacket(16, 1, 1'b0);

        // Rejected commands with four bytes buffered; the last entry has start low.
        errTable[0] = '{1'b1, 5,  3,            1'b1};
        errTable[1] = '{1'b1, 0,  1,            1'b1};
        errTable[2] = '{1'b1, 10, 0,            1'b1};
        errTable[3] = '{1'b1, 5,  2,            1'b1};
        errTable[4] = '{1'b1, 4,  ADDR_INVALID, 1'b1};
        errTable[5] = '{1'b1, MAX_LEN, 0,       1'b1};
        errTable[6] = '{1'b0, 4,  1,            1'b0};
        for (int i = 0; i < 4; i++) pushByte(8'($urandom));
        for (int i = 0; i < 7; i++) begin
            bus.start    = errTable[i].startV;
            bus.cmd_len  = 6'(errTable[i].len);
            bus.cmd_addr = 2'(errTable[i].addr);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            bus.start = 1'b0;
            checkOutput("cmd_err_pulse", 32'(bus.cmd_err), 32'(errTable[i].expErr));
            checkOutput("err_pkt_valid", 32'(bus.pkt_valid), 32'd0);
            checkOutput("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            checkOutput("err_tx_active", 32'(bus.tx_active), 32'd0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("cmd_err_clear", 32'(bus.cmd_err), 32'd0);
        end
        runPacket(4, 0, 1'b0);

        // Overfill, then a maximum-length packet with host writes racing the pops.
        for (int i = 0; i < DEPTH + 1; i++) pushByte(8'($urandom));
        randWr = 1'b1;
        runPacket(MAX_LEN, 1, 1'b0);

        for (int iter = 0; iter < 8; iter++) begin
            randWr = 1'b0;
            room = DEPTH - modelQ.size();
            for (int i = $urandom_range(0, room); i > 0; i--) pushByte(8'($urandom));
            if (modelQ.size() == 0) pushByte(8'($urandom));
            len  = $urandom_range(1, (modelQ.size() < MAX_LEN) ? modelQ.size() : MAX_LEN);
            addr = $urandom_range(0, 2);
            for (int k = 0; k <= len + 1; k++)
                hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            randWr = 1'($urandom_range(0, 1));
            runPacket(len, addr, 1'b0);
        end
        randWr = 1'b0;

        // Reset in the middle of a payload, then a clean packet afterwards.
        while (modelQ.size() < 14) pushByte(8'($urandom));
        bus.start    = 1'b1;
        bus.cmd_len  = 6'd14;
        bus.cmd_addr = PORT0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        bus.start = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("mid_pkt_valid", 32'(bus.pkt_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("arst_pkt_data", 32'(bus.pkt_data), 32'd0);
        checkOutput("arst_buf_count", 32'(bus.buf_count), 32'd0);
        checkOutput("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("arst_tx_active", 32'(bus.tx_active), 32'd0);
        modelQ.delete();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pushByte(8'($urandom));
        runPacket(3, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Ingress packet framer that sits directly upstream of the 1x3 router and drives its pkt_valid/data_in input under control of its busy output.
- The host side loads payload bytes into an internal FIFO, then issues a send command carrying length and destination address.
- The block emits the header byte {len[5:0], addr[1:0]}, then the payload bytes, then an even-XOR parity byte. It stalls on busy.

Parameters:
- DATA_W, 8, byte width of payload and router data path.
- DEPTH, 64, payload buffer depth in bytes (must be >= 63, the maximum packet length).
- CNT_W, 7, width of the buffer occupancy count (log2(DEPTH)+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host pushes wr_data into the payload buffer.
- wr_data  in  8  payload byte.
- buf_full  out  1  payload buffer full.
- buf_count  out  7  current buffer occupancy.
- wr_ovf  out  1  one-cycle pulse: wr_en arrived while full; the byte is dropped.
- start  in  1  send-command strobe.
- cmd_len  in  6  payload length, legal range 1..63.
- cmd_addr  in  2  destination port 0..2; 3 is illegal.
- cmd_ready  out  1  high in IDLE; a start is only considered while this is high.
- cmd_err  out  1  one-cycle pulse: command rejected.
- busy  in  1  router busy; a byte is held while this is high.
- pkt_valid  out  1  to router.
- pkt_data  out  8  to router data_in.
- tx_active  out  1  high from header presentation until parity is accepted.
- tx_done  out  1  one-cycle pulse on the edge that accepts the parity byte.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. The buffer is emptied, the FSM goes to IDLE, and parity is cleared. Reset mid-packet aborts immediately; pkt_valid drops asynchronously.
- Byte acceptance: a presented byte is accepted at any rising edge with busy=0. pkt_data and pkt_valid are registered and change only on an accepting edge or on a state entry.
- FSM states:
  - IDLE: cmd_ready=1, pkt_valid=0, pkt_data=0.
  - IDLE -> HEADER when start=1 with a legal command and buf_count >= cmd_len. The command is latched.
  - IDLE stays IDLE with a cmd_err pulse on the next cycle when start=1 and any of: cmd_addr=3, cmd_len=0, or buf_count < cmd_len.
  - HEADER: state entry is the cycle after start. pkt_valid=1, pkt_data={len,addr}, parity initialised to the header value. On accept -> PAYLOAD, and the first FIFO byte is presented.
  - PAYLOAD: pkt_valid=1. On each accept, the byte is XORed into parity, the FIFO pops, and the next byte is presented. A remaining counter starts at len. When the last payload byte is accepted -> PARITY.
  - PARITY: pkt_valid=0, pkt_data=accumulated parity. On accept, tx_done pulses and the FSM returns to IDLE; pkt_data clears to 0.
- Latency: start edge T -> header presented from T+1. With busy=0 throughout, the parity byte is accepted at T+len+2 and tx_done is high for the cycle following that edge.
- busy held high for N cycles holds the current byte and pkt_valid stable for N cycles. No byte is skipped or duplicated.
- Buffer:
  - Push and pop on the same edge: count unchanged.
  - Push when full: dropped, wr_ovf pulse.
  - The FSM never pops an empty buffer; this is guaranteed by the start-time length check.
  - Pointers wrap modulo DEPTH.
- Host writes during transmission are permitted. Extra bytes remain buffered for the next packet.
- start while not IDLE is ignored, with no cmd_err.
- Parity is the XOR of the header and all payload bytes, 8 bits.

Decomposition:
- Shared package router_pkg:
  - Header field positions: LEN bits [7:2], ADDR bits [1:0].
  - Address constants PORT0=0, PORT1=1, PORT2=2, ADDR_INVALID=3.
  - MAX_LEN=63, the DATA_W default, and the FSM state enum {IDLE, HEADER, PAYLOAD, PARITY}.
- Sub-module: router_tx_fifo, a synchronous FIFO with push/pop, full/empty/count and show-ahead head output. The FSM is top-level.

Test Plan:
1. Push bytes 0x01..0x05, start len=5 addr=2, busy=0 -> bytes 0x16, 01, 02, 03, 04, 05 with pkt_valid=1, then 0x17 with pkt_valid=0. tx_done pulses once; buf_count returns to 0.
2. Push 14 random bytes, start len=14 addr=0 -> header 0x38. Parity equals the header XORed with the payload, matched against the scoreboard. Repeat with len=16 addr=1 -> header 0x41.
3. Same as case 1, with busy forced high for 3 cycles on the header, payload byte 3 and the parity byte -> each byte held exactly 3 extra cycles, with an identical output sequence.
4. Command errors: start with addr=3; start with len=0; start with len=10 and buf_count=4 -> cmd_err pulse each time, pkt_valid stays 0, FSM stays IDLE.
5. Push 65 bytes with DEPTH=64 -> buf_full=1 after 64, wr_ovf pulses on the 65th, count=64. Simultaneous push/pop during a packet leaves count unchanged.
6. Assert rst in the middle of the payload of case 2 -> pkt_valid=0 immediately, buffer empty, cmd_ready=1. A following legal packet transmits correctly.
